// File: rtl/ws_pkg.sv
// Shared constants, result word type and pointer-width helper for the WS array result path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ws_pkg;

    localparam int IN_WORD_SIZE  = 8;
    localparam int OUT_WORD_SIZE = 16;
    localparam int ROW           = 3;
    localparam int COLUMN        = 3;

    typedef logic signed [OUT_WORD_SIZE-1:0] result_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int n;
        n = 0;
        while ((1 << n) < value) n++;
        return n;
    endfunction

endpackage

// File: rtl/ws_result_deskew_if.sv
// Handshake bundle between the array's last column, the deskew stage and the writeback consumer.
// Latency: none (wires only).
// Backpressure: out_ready only; the input side has no ready because the array cannot stall.
interface ws_result_deskew_if
    import ws_pkg::*;
#(
    parameter int out_word_size = OUT_WORD_SIZE,
    parameter int row           = ROW
);
    logic [0:row-1][out_word_size-1:0] Result_in;
    logic                              in_valid;
    logic [0:row-1][out_word_size-1:0] out_data;
    logic                              out_valid;
    logic                              out_ready;

    modport master (
        output Result_in, in_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  Result_in, in_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/ws_vec_fifo.sv
// Synchronous FIFO of whole aligned vectors; head is read straight from storage.
// Latency: push visible at the head one cycle later; no bypass when empty.
// Backpressure: push refused when full unless a pop happens in the same cycle.
module ws_vec_fifo
    import ws_pkg::*;
#(
    parameter int width = 48,
    parameter int depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [width-1:0]       push_data,
    input  logic                   pop,
    output logic [width-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(depth):0]  count
);
    localparam int PW = clog2(depth);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(depth));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Vector storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; occupancy tracks push minus pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ws_result_deskew.sv
// Re-aligns row-staggered partial sums into whole vectors, optional ReLU, then buffers them.
// Latency: in_valid at cycle t reaches out_valid at cycle t+row when the FIFO is empty.
// Backpressure: out_ready stalls the FIFO head; a full FIFO drops the vector and sets overflow.
module ws_result_deskew
    import ws_pkg::*;
#(
    parameter int out_word_size = OUT_WORD_SIZE,
    parameter int row           = ROW,
    parameter int fifo_depth    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        relu_en,
    input  logic                        clr_overflow,
    output logic [clog2(fifo_depth):0]  occupancy,
    output logic                        overflow,
    ws_result_deskew_if.slave           bus
);
    logic [out_word_size-1:0]          aligned [row];
    logic [0:row-1][out_word_size-1:0] wr_vec;
    logic [row*out_word_size-1:0]      head;
    logic                              aligned_valid;
    logic                              pop_fire;
    logic                              full;
    logic                              empty;
    logic                              drop;

    // Row r waits row-1-r cycles so it lines up with the last row.
    for (genvar r = 0; r < row; r++) begin : g_row
        localparam int DLY = row - 1 - r;
        if (DLY == 0) begin : g_pass
            assign aligned[r] = bus.Result_in[r];
        end else begin : g_dly
            logic [out_word_size-1:0] dly [DLY];
            // Free-running delay line; valid is tracked separately.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DLY; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= bus.Result_in[r];
                    for (int i = 1; i < DLY; i++) dly[i] <= dly[i-1];
                end
            end
            assign aligned[r] = dly[DLY-1];
        end
    end

    // Valid follows row 0 through the same number of stages.
    if (row > 1) begin : g_vpipe
        logic [row-2:0] vpipe;
        // Shift in_valid toward aligned_valid; reset discards in-flight vectors.
        always_ff @(posedge clk) begin
            if (rst) vpipe <= '0;
            else     vpipe <= (vpipe << 1) | (row-1)'(bus.in_valid);
        end
        assign aligned_valid = vpipe[row-2];
    end else begin : g_novpipe
        assign aligned_valid = bus.in_valid;
    end

    // ReLU on the aligned vector just ahead of the FIFO write.
    always_comb begin
        wr_vec = '0;
        for (int r = 0; r < row; r++) begin
            wr_vec[r] = (relu_en && aligned[r][out_word_size-1]) ? '0 : aligned[r];
        end
    end

    assign pop_fire = bus.out_valid && bus.out_ready;
    assign drop     = aligned_valid && full && !pop_fire;

    ws_vec_fifo #(
        .width (row * out_word_size),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (aligned_valid),
        .push_data (wr_vec),
        .pop       (pop_fire),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (occupancy)
    );

    assign bus.out_data  = head;
    assign bus.out_valid = !empty;

    // Sticky drop flag; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)               overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

endmodule

// File: doc/ws_result_deskew.md
Name: ws_result_deskew

Overview:
- Downstream neighbour of the weight-stationary systolic array.
- Consumes the row-staggered partial-sum outputs of the array's last column. Row r of a given output vector arrives r cycles after row 0.
- Delays each row so all rows of one vector line up, optionally applies signed ReLU, and buffers whole vectors in a small FIFO with a valid/ready interface toward the writeback/pooling stage.
- The array cannot stall, so an overflow is dropped and flagged rather than back-pressured.

Parameters:
- out_word_size, 16, width of each partial-sum word (two's complement).
- row, 3, number of array rows = number of words per output vector (>=1).
- fifo_depth, 4, number of aligned vectors buffered (power of 2, >=2).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- Result_in  input  out_word_size x [0:row-1]  staggered partial sums from array Result_out.
- in_valid  input  1  asserted in the cycle Result_in[0] carries row 0 of a valid vector.
- relu_en  input  1  quasi-static; when 1, negative words are replaced by 0 at the FIFO write.
- out_data  output  out_word_size x [0:row-1]  head-of-FIFO aligned vector.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- occupancy  output  $clog2(fifo_depth)+1  number of vectors currently held.
- overflow  output  1  sticky; set when a completed vector is dropped because the FIFO is full.
- clr_overflow  input  1  clears overflow (set has priority in the same cycle).

Behaviour:
- Reset values: out_valid=0, occupancy=0, overflow=0, out_data=0. All delay registers and FIFO pointers are zero. The valid pipeline is cleared, so in-flight vectors are discarded.
- Deskew:
  - Row r passes through (row-1-r) registers.
  - Row row-1 is not delayed.
  - in_valid passes through a (row-1)-stage shift register, producing aligned_valid.
  - row=1 means no delay stages.
- Row data registers shift every cycle regardless of valid. Only aligned_valid qualifies a write.
- ReLU: applied combinationally on the aligned vector before the FIFO write: word[msb]=1 and relu_en=1 -> 0. Sampled in the cycle of the write.
- Write: aligned_valid=1 and (not full, or a pop in the same cycle) -> write vector, advance write pointer.
- Full and no pop: vector dropped, pointers unchanged, overflow <= 1 next cycle.
- Pop: out_valid && out_ready -> advance read pointer.
- Simultaneous push and pop:
  - Both happen; occupancy is unchanged.
  - When full, the push succeeds because the pop frees a slot.
  - When empty, only the push happens: no bypass, and out_valid rises the next cycle.
- Latency: in_valid at cycle t into an empty FIFO -> out_valid=1 and out_data valid at cycle t+row.
- out_data is registered/read from storage. It must stay stable while out_valid && !out_ready.
- Pointers are $clog2(fifo_depth) bits with natural wrap. Full/empty are derived from occupancy.
- Back-to-back in_valid (every cycle) is sustained at one vector per cycle when out_ready=1.
- overflow: set wins over clr_overflow when both occur in the same cycle. Only rst or clr_overflow clears it.
- in_valid during reset is ignored.

Decomposition:
- Package ws_pkg:
  - Default constants IN_WORD_SIZE, OUT_WORD_SIZE, ROW, COLUMN.
  - typedef of a result word, signed logic [OUT_WORD_SIZE-1:0].
  - Function clog2 for pointer widths.
- Sub-module ws_vec_fifo: a synchronous FIFO of row-wide vectors (push, pop, full, empty, count), instantiated once.
- Deskew delay lines and the ReLU are a generate loop in the top module.

Test Plan (row=3, fifo_depth=4, out_word_size=16):
- Single vector: in_valid at cycle 0 with Result_in[0]=1, Result_in[1]=2 at cycle 1, Result_in[2]=3 at cycle 2, out_ready=1. Required: out_valid=1 at cycle 3 with out_data={1,2,3}, then out_valid=0 at cycle 4.
- Streaming: in_valid every cycle for 8 vectors, vector k = {k, 10+k, 20+k} staggered, out_ready=1. Required: 8 in-order vectors on consecutive cycles 3..10, occupancy never exceeds 1, overflow=0.
- Back-pressure/overflow: out_ready=0, 5 vectors issued. Required:
  - occupancy reaches 4.
  - 5th vector dropped; overflow=1 one cycle after its aligned write.
  - Then out_ready=1 drains exactly vectors 0..3, with out_data stable while stalled.
  - clr_overflow=1 clears overflow next cycle.
- Full with simultaneous push/pop: FIFO at 4, out_ready=1 in the same cycle a vector completes. Required: occupancy stays 4, no overflow, order preserved.
- ReLU: relu_en=1, vector {-5, 0, 7} (0xFFFB, 0, 7). Required: out_data={0,0,7}. With relu_en=0, out_data={0xFFFB,0,7}.
- Reset mid-operation: rst=1 for one cycle while 2 vectors are in the deskew pipeline and 2 are in the FIFO. Required: next cycle out_valid=0, occupancy=0, overflow=0, and no stale vector emerges in the following 5 cycles.
